com_bus_arbiter: RTL and testbench
==================================

Name: com_bus_arbiter

Overview:
- Arbitrates the shared coherence bus (Address_Com / Data_Bus_Com / Data_in_Bus) among the per-core cache wrappers.
- Consumes each cache's Com_Bus_Req_proc and drives the matching Com_Bus_Gnt_proc.
- Sits directly downstream of the four cache units at the top level.
- Round-robin, grant held for the whole transaction, one mandatory idle turnaround cycle between owners so the inout buses never see two drivers.

Parameters:
NUM_PROC, 4, number of cache units/requesters (>=2)
ID_W, 2, width of owner index; must equal clog2(NUM_PROC)
MAX_TENURE, 64, max consecutive grant cycles before forced release (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
Com_Bus_Req_proc  input  NUM_PROC  request vector, bit i from cache i; level, held until granted and through transaction
Com_Bus_Gnt_proc  output  NUM_PROC  one-hot-or-zero grant vector, registered
Gnt_id  output  ID_W  index of current/last owner, valid while Bus_busy=1
Bus_busy  output  1  high in GRANT and TURN states
Timeout_err  output  1  sticky forced-release flag (0 when feature compiled out)

Behaviour:
- Reset (async assert, sync-safe deassert): Com_Bus_Gnt_proc=0, Gnt_id=0, Bus_busy=0, Timeout_err=0, state=IDLE, last_owner=NUM_PROC-1 (so cache 0 wins first).
- States: IDLE, GRANT, TURN. All outputs are flops; no combinational req->gnt path.
- Arbitration function: winner = first i with req[i]=1, scanning (last_owner+1) mod NUM_PROC upward with wrap.
- IDLE: if any req bit =1 at edge -> next cycle state=GRANT, gnt one-hot at winner, Gnt_id=winner, Bus_busy=1. Latency: req high at edge N -> gnt high after edge N (visible cycle N+1). No req -> stay IDLE, outputs 0.
- GRANT: hold gnt while req[Gnt_id]=1. Other requests ignored, remain pending. When req[Gnt_id] sampled 0 -> gnt=0, last_owner=Gnt_id, state=TURN.
- TURN: exactly one cycle, gnt=0, Bus_busy=1. Then: any req -> GRANT with new winner (pointer already advanced); none -> IDLE, Bus_busy=0.
- Minimum spacing between consecutive grants to different or same owner: 1 zero-grant cycle.
- Requester withdraws req before grant: simply not selected; no error.
- Single requester repeating: grant, release, TURN, re-grant same index (fairness pointer wraps onto it since no one else requests).
- All NUM_PROC requesting continuously: grants rotate 0,1,2,3,0,... each separated by TURN.
- Reset mid-GRANT: gnt drops immediately (async), pointer returns to NUM_PROC-1.
- Gnt_id retains last owner in IDLE (not cleared) except on reset.
- Com_Bus_Gnt_proc never has >1 bit set (assertion required in bench).

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: tenure counter (clog2(MAX_TENURE+1) bits) clears on entering GRANT, increments each GRANT cycle. When count reaches MAX_TENURE with owner req still 1: force gnt=0, go TURN, last_owner=owner, set Timeout_err=1 (sticky until reset). The timed-out owner's req is masked from arbitration until it samples 0 once, then unmasked.
- Not defined: no counter, no mask, grant held indefinitely, Timeout_err tied 0.

Test Plan:
- Reset then req=4'b0100 held 3 cycles then 0 -> gnt=4'b0100 from cycle 1 to the cycle after req drops; then 1 TURN cycle with gnt=0, Bus_busy=1; then IDLE, Bus_busy=0.
- req=4'b1111 held permanently, each owner drops its own bit 2 cycles after grant and re-raises it -> grant order 0,1,2,3,0; Gnt_id 0,1,2,3,0; gnt=0 exactly one cycle between each.
- Owner 1 granted; req[3] raised mid-tenure; req[1] drops -> TURN, then gnt=4'b1000, last_owner=1 before selection.
- rst_n low for 1 cycle while gnt=4'b0010 -> gnt=0 immediately; after release with req=4'b1010, gnt=4'b0010 (pointer reset to 3, scan from 0).
- ARB_TIMEOUT_EN, MAX_TENURE=8, req[2] held forever, req[0]=1 -> gnt[2] high 8 cycles, forced TURN, Timeout_err=1, gnt=4'b0001 next; cache 2 not re-granted until req[2] drops and re-rises.
- Without macro, same stimulus -> gnt[2] held indefinitely, Timeout_err=0.

Source files
------------

// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: round-robin owner arbiter for the shared coherence bus.
// Define ARB_TIMEOUT_EN to add a tenure limit with a sticky Timeout_err.
module com_bus_arbiter #(
   parameter int NUM_PROC   = 4,
   parameter int ID_W       = 2,
   parameter int MAX_TENURE = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_PROC-1:0] Com_Bus_Req_proc,
   output logic [NUM_PROC-1:0] Com_Bus_Gnt_proc,
   output logic [ID_W-1:0]     Gnt_id,
   output logic                Bus_busy,
   output logic                Timeout_err
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t              state, state_d;
   logic [ID_W-1:0]     last_owner, last_d;
   logic [ID_W-1:0]     id_d, winner, sel;
   logic [NUM_PROC-1:0] gnt_d, eligible, own_bit;
   logic                busy_d, found, owner_req, expire;
   int                  idx;

   if (MAX_TENURE < 1 || ID_W != $clog2(NUM_PROC)) begin : g_bad_cfg
      $error("com_bus_arbiter: inconsistent parameters");
   end

   assign owner_req = Com_Bus_Req_proc[Gnt_id];
   assign own_bit   = NUM_PROC'(1) << Gnt_id;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_TENURE + 1);

   logic [CNT_W-1:0]    tenure;
   logic [NUM_PROC-1:0] mask;
   logic                err;

   assign expire = (state == GRANT) && owner_req &&
                   (tenure == CNT_W'(MAX_TENURE - 1));
   assign eligible    = Com_Bus_Req_proc & ~mask;
   assign Timeout_err = err;

   // A timed-out owner stays masked until it drops its request once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tenure <= '0;
         mask   <= '0;
         err    <= 1'b0;
      end else begin
         tenure <= (state == GRANT) ? tenure + 1'b1 : '0;
         mask   <= (mask & Com_Bus_Req_proc) | (expire ? own_bit : '0);
         if (expire) err <= 1'b1;
      end
   end
`else
   assign expire      = 1'b0;
   assign eligible    = Com_Bus_Req_proc;
   assign Timeout_err = 1'b0;
`endif

   // Scan upward from the slot after the last owner, with wrap.
   always_comb begin
      winner = last_owner;
      found  = 1'b0;
      idx    = 0;
      sel    = '0;
      for (int k = 1; k <= NUM_PROC; k++) begin
         idx = (int'(last_owner) + k) % NUM_PROC;
         sel = ID_W'(idx);
         if (!found && eligible[sel]) begin
            found  = 1'b1;
            winner = sel;
         end
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE, TURN: state_d = found ? GRANT : IDLE;
         GRANT:      if (!owner_req || expire) state_d = TURN;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d  = '0;
      id_d   = Gnt_id;
      last_d = last_owner;
      busy_d = 1'b0;
      unique case (state_d)
         GRANT: begin
            busy_d = 1'b1;
            if (state != GRANT) id_d = winner;
            gnt_d[id_d] = 1'b1;
         end
         TURN: begin
            busy_d = 1'b1;
            last_d = Gnt_id;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         Com_Bus_Gnt_proc <= '0;
         Gnt_id           <= '0;
         Bus_busy         <= 1'b0;
         last_owner       <= ID_W'(NUM_PROC - 1);
      end else begin
         state            <= state_d;
         Com_Bus_Gnt_proc <= gnt_d;
         Gnt_id           <= id_d;
         Bus_busy         <= busy_d;
         last_owner       <= last_d;
      end
   end

endmodule

// File: tb/tb_com_bus_arbiter.sv
// tb_com_bus_arbiter: directed stimulus, cycle model and literal checks.
// Built with or without ARB_TIMEOUT_EN; bench uses MAX_TENURE = 8.
module tb_com_bus_arbiter;

   localparam int MAXT = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0;
   logic [3:0] gnt;
   logic [1:0] gid;
   logic       busy;
   logic       terr;

   int cmp = 0;
   int mis = 0;

   com_bus_arbiter #(
      .NUM_PROC  (4),
      .ID_W      (2),
      .MAX_TENURE(MAXT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .Com_Bus_Req_proc(req),
      .Com_Bus_Gnt_proc(gnt),
      .Gnt_id          (gid),
      .Bus_busy        (busy),
      .Timeout_err     (terr)
   );

   always #5 clk = ~clk;

   // Model: who owns the bus, whether we sit in the turnaround slot,
   // how many cycles the owner has held it, and the fairness pointer.
   int         m_owner = -1;
   bit         m_turn  = 1'b0;
   int         m_last  = 3;
   int         m_id    = 0;
   int         m_held  = 0;
   bit         m_err   = 1'b0;
   logic [3:0] m_mask  = 4'b0;
   logic [3:0] r, cand;
   int         w;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_turn  = 1'b0;
         m_last  = 3;
         m_id    = 0;
         m_held  = 0;
         m_err   = 1'b0;
         m_mask  = 4'b0;
      end else begin
         r    = req;
         cand = r;
`ifdef ARB_TIMEOUT_EN
         cand   = r & ~m_mask;
         m_mask = m_mask & r;
`endif
         if (m_owner >= 0) begin
            if (!r[m_owner[1:0]]) begin
               m_last  = m_owner;
               m_owner = -1;
               m_turn  = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_held == MAXT) begin
               m_mask[m_owner[1:0]] = 1'b1;
               m_err   = 1'b1;
               m_last  = m_owner;
               m_owner = -1;
               m_turn  = 1'b1;
            end
`endif
            else m_held++;
         end else begin
            m_turn = 1'b0;
            w = -1;
            for (int k = 1; k <= 4; k++) begin
               if (w < 0 && cand[2'((m_last + k) % 4)]) w = (m_last + k) % 4;
            end
            if (w >= 0) begin
               m_owner = w;
               m_id    = w;
               m_held  = 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   logic [3:0] e_gnt;

   always @(negedge clk) begin
      e_gnt = (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0;
      chk("model_gnt", 32'(gnt), 32'(e_gnt));
      chk("model_busy", 32'(busy), 32'(m_owner >= 0 || m_turn));
      chk("model_id", 32'(gid), 32'(m_id));
      chk("model_err", 32'(terr), 32'(m_err));
      cmp++;
      assert ($onehot0(gnt)) else begin
         mis++;
         $display("FAIL onehot0 at %0t: got %b want at most one bit", $time, gnt);
      end
   end

   task automatic cyc(input logic [3:0] v);
      req = v;
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_id", 32'(gid), 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   int seq[5] = '{0, 1, 2, 3, 0};

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_id", 32'(gid), 32'h0);
      chk("reset_err", 32'(terr), 32'h0);
      rst_n = 1'b1;

      // Single requester: grant, hold, one turnaround, idle.
      cyc(4'b0100);
      chk("t1_gnt", 32'(gnt), 32'h4);
      chk("t1_id", 32'(gid), 32'h2);
      cyc(4'b0100);
      cyc(4'b0100);
      cyc(4'b0000);
      chk("t1_turn_gnt", 32'(gnt), 32'h0);
      chk("t1_turn_busy", 32'(busy), 32'h1);
      cyc(4'b0000);
      chk("t1_idle_busy", 32'(busy), 32'h0);
      chk("t1_idle_id", 32'(gid), 32'h2);

      // Everyone requesting: rotation 0,1,2,3,0.
      pulse_reset();
      foreach (seq[n]) begin
         cyc(4'b1111);
         chk("rr_gnt", 32'(gnt), 32'(4'b1 << seq[n]));
         chk("rr_id", 32'(gid), 32'(seq[n]));
         cyc(4'b1111);
         cyc(4'b1111 & ~(4'b1 << seq[n]));
         chk("rr_turn_gnt", 32'(gnt), 32'h0);
         chk("rr_turn_busy", 32'(busy), 32'h1);
      end
      cyc(4'b0000);

      // Late request from 3 waits for owner 1 to finish.
      cyc(4'b0010);
      chk("t3_gnt1", 32'(gnt), 32'h2);
      cyc(4'b0010);
      cyc(4'b1010);
      chk("t3_hold", 32'(gnt), 32'h2);
      cyc(4'b1000);
      chk("t3_turn", 32'(gnt), 32'h0);
      cyc(4'b1000);
      chk("t3_gnt3", 32'(gnt), 32'h8);
      chk("t3_id3", 32'(gid), 32'h3);
      cyc(4'b0000);
      cyc(4'b0000);

      // Reset during a grant; pointer restarts so 1 beats 3.
      cyc(4'b0010);
      chk("t4_pre", 32'(gnt), 32'h2);
      req = 4'b1010;
      pulse_reset();
      cyc(4'b1010);
      chk("t4_post", 32'(gnt), 32'h2);
      cyc(4'b0000);
      cyc(4'b0000);

      // Requester 2 never lets go while 0 waits.
      cyc(4'b0101);
      chk("t5_gnt2", 32'(gnt), 32'h4);
      repeat (MAXT - 1) cyc(4'b0101);
      chk("t5_still2", 32'(gnt), 32'h4);
`ifdef ARB_TIMEOUT_EN
      cyc(4'b0101);
      chk("t5_forced_gnt", 32'(gnt), 32'h0);
      chk("t5_forced_busy", 32'(busy), 32'h1);
      chk("t5_err", 32'(terr), 32'h1);
      cyc(4'b0101);
      chk("t5_gnt0", 32'(gnt), 32'h1);
      cyc(4'b0100);
      cyc(4'b0100);
      chk("t5_masked", 32'(gnt), 32'h0);
      chk("t5_masked_busy", 32'(busy), 32'h0);
      cyc(4'b0000);
      cyc(4'b0100);
      chk("t5_regrant2", 32'(gnt), 32'h4);
      chk("t5_err_sticky", 32'(terr), 32'h1);
`else
      repeat (20) cyc(4'b0101);
      chk("t5_held2", 32'(gnt), 32'h4);
      chk("t5_no_err", 32'(terr), 32'h0);
`endif
      cyc(4'b0000);
      cyc(4'b0000);
      chk("end_idle", 32'(busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end

endmodule
